// File: rtl/adder_defs.sv
// Shared definitions for the chunked arithmetic blocks: FSM state encoding
// and helpers that size the chunk count and chunk index.
package adder_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned nchunk_of(input int unsigned width,
                                            input int unsigned chunk);
    return width / chunk;
  endfunction

  // Index register is at least one bit wide, even for a single chunk.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple of full-adder cells; also exposes the
// carry into the top bit so the caller can form signed overflow.
module chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  always_comb begin : ripple
    logic cy;
    cy    = ci;
    s     = '0;
    c_msb = ci;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb = cy;
      s[i] = x[i] ^ y[i] ^ cy;
      cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    co = cy;
  end

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, holding the
// carry between chunks, with a start/ready/valid handshake and result flags.
module chunked_adder
  import adder_defs::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NCHUNK = nchunk_of(WIDTH, CHUNK);
  localparam int unsigned IW     = idx_bits(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, sum_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic             cout_q, ovf_q, zero_q;
  logic [31:0]      base;
  logic [CHUNK-1:0] x, y, s;
  logic             co, c_msb;
  logic             accept, last;

  always_comb begin
    base  = 32'(idx_q) * CHUNK;
    x     = a_q[base +: CHUNK];
    y     = b_q[base +: CHUNK];
    acc_d = acc_q;
    acc_d[base +: CHUNK] = s;
  end

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x     (x),
    .y     (y),
    .ci    (carry_q),
    .s     (s),
    .co    (co),
    .c_msb (c_msb)
  );

  always_comb begin
    state_d = state_q;
    ready   = (state_q != ST_RUN);
    valid   = (state_q == ST_DONE);
    accept  = ready & start;
    last    = (idx_q == LAST);
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (last) state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // acc_q fills chunk by chunk; the visible sum/flags move only on the last
  // chunk, so outputs hold the previous result throughout RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub ? 1'b1 : cin;
        idx_q   <= '0;
      end else if (state_q == ST_RUN) begin
        acc_q   <= acc_d;
        carry_q <= co;
        idx_q   <= idx_q + IW'(1);
        if (last) begin
          sum_q  <= acc_d;
          cout_q <= co;
          ovf_q  <= co ^ c_msb;
          zero_q <= (acc_d == '0);
        end
      end
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder across several WIDTH/CHUNK configurations.
module tb_chunked_adder;

  localparam int WID [5] = '{8, 32, 8, 8, 16};
  localparam int NCH [5] = '{2, 4, 8, 1, 4};

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  start, rdy, vld, co, ov, z;
  logic [31:0] a, b;
  logic        sub, cin;
  logic [7:0]  s0, s2, s3;
  logic [31:0] s1;
  logic [15:0] s4;
  logic [31:0] sumv [5];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(8), .CHUNK(4)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .ready(rdy[0]), .a(a[7:0]), .b(b[7:0]),
    .sub(sub), .cin(cin), .valid(vld[0]), .sum(s0), .cout(co[0]), .overflow(ov[0]), .zero(z[0]));
  chunked_adder #(.WIDTH(32), .CHUNK(8)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .ready(rdy[1]), .a(a), .b(b),
    .sub(sub), .cin(cin), .valid(vld[1]), .sum(s1), .cout(co[1]), .overflow(ov[1]), .zero(z[1]));
  chunked_adder #(.WIDTH(8), .CHUNK(1)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .ready(rdy[2]), .a(a[7:0]), .b(b[7:0]),
    .sub(sub), .cin(cin), .valid(vld[2]), .sum(s2), .cout(co[2]), .overflow(ov[2]), .zero(z[2]));
  chunked_adder #(.WIDTH(8), .CHUNK(8)) u3 (
    .clk(clk), .reset(reset), .start(start[3]), .ready(rdy[3]), .a(a[7:0]), .b(b[7:0]),
    .sub(sub), .cin(cin), .valid(vld[3]), .sum(s3), .cout(co[3]), .overflow(ov[3]), .zero(z[3]));
  chunked_adder #(.WIDTH(16), .CHUNK(4)) u4 (
    .clk(clk), .reset(reset), .start(start[4]), .ready(rdy[4]), .a(a[15:0]), .b(b[15:0]),
    .sub(sub), .cin(cin), .valid(vld[4]), .sum(s4), .cout(co[4]), .overflow(ov[4]), .zero(z[4]));

  always_comb begin
    sumv[0] = {24'b0, s0};
    sumv[1] = s1;
    sumv[2] = {24'b0, s2};
    sumv[3] = {24'b0, s3};
    sumv[4] = {16'b0, s4};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] ref_calc(input int w, input logic [31:0] aa, input logic [31:0] bb,
                                           input logic sb, input logic ci);
    logic [63:0] m, bo, full;
    logic [31:0] r;
    logic        c, o, zz, sa, sbb, sr;
    m    = (64'd1 << w) - 64'd1;
    bo   = sb ? (~{32'b0, bb} & m) : ({32'b0, bb} & m);
    full = ({32'b0, aa} & m) + bo + (sb ? 64'd1 : {63'b0, ci});
    r    = full[31:0] & m[31:0];
    c    = full[w];
    sa   = aa[w-1];
    sbb  = bo[w-1];
    sr   = r[w-1];
    o    = (sa == sbb) && (sr != sa);
    zz   = (r == 32'd0);
    return {zz, o, c, r};
  endfunction

  task automatic run_op(input int k, input logic [31:0] aa, input logic [31:0] bb,
                        input logic sb, input logic ci, input logic [31:0] es,
                        input logic ec, input logic eo, input logic ez,
                        input string tag, input bit poke);
    logic [31:0] prev;
    int          cycles, extra;
    bit          hold_ok;
    @(negedge clk);
    a = aa; b = bb; sub = sb; cin = ci; start[k] = 1'b1;
    prev = sumv[k];
    @(posedge clk); #1;
    start[k] = 1'b0;
    a = ~aa; b = ~bb; sub = ~sb; cin = ~ci;
    chk({tag, " ready_low"}, {31'b0, rdy[k]}, 32'd0);
    cycles  = 0;
    hold_ok = 1'b1;
    while (!vld[k] && cycles < 100) begin
      @(negedge clk);
      if (poke && cycles == 0) begin
        start[k] = 1'b1; a = 32'h100; b = 32'h1; sub = 1'b0;
      end
      @(posedge clk); #1;
      start[k] = 1'b0;
      cycles++;
      if (!vld[k] && sumv[k] !== prev) hold_ok = 1'b0;
    end
    chk({tag, " latency"}, cycles, NCH[k]);
    chk({tag, " sum_hold"}, {31'b0, hold_ok}, 32'd1);
    chk({tag, " sum"}, sumv[k], es);
    chk({tag, " cout"}, {31'b0, co[k]}, {31'b0, ec});
    chk({tag, " overflow"}, {31'b0, ov[k]}, {31'b0, eo});
    chk({tag, " zero"}, {31'b0, z[k]}, {31'b0, ez});
    if (poke) begin
      extra = 0;
      repeat (NCH[k] + 2) begin
        @(posedge clk); #1;
        if (vld[k]) extra++;
      end
      chk({tag, " no_extra_valid"}, extra, 32'd0);
      chk({tag, " ready_after"}, {31'b0, rdy[k]}, 32'd1);
    end
  endtask

  initial begin
    logic [34:0] e;
    logic [31:0] ra, rb;
    logic        rs, rc;
    int          pulses, first_e, last_e, cnt;

    reset = 1'b1; start = '0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("reset ready", {31'b0, rdy[k]}, 32'd1);
      chk("reset valid", {31'b0, vld[k]}, 32'd0);
      chk("reset sum", sumv[k], 32'd0);
      chk("reset flags", {29'b0, co[k], ov[k], z[k]}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    run_op(0, 32'h0F, 32'h01, 1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0, "w8c4 0f+01", 1'b0);
    run_op(0, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0, "w8c4 7f+01", 1'b0);
    run_op(0, 32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, "w8c4 ff+01", 1'b0);
    run_op(1, 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "w32c8 5-7 busy", 1'b1);
    run_op(1, 32'd7, 32'd5, 1'b1, 1'b0, 32'd2, 1'b1, 1'b0, 1'b0, "w32c8 7-5", 1'b0);
    run_op(2, 32'h80, 32'h01, 1'b1, 1'b0, 32'h7F, 1'b1, 1'b1, 1'b0, "w8c1 80-01", 1'b0);
    run_op(3, 32'h00, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, "w8c8 00-00", 1'b0);
    run_op(4, 32'hFFFF, 32'h0000, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, "w16c4 ffff+0+1", 1'b0);

    // start held high: results every NCHUNK+1 cycles
    @(negedge clk);
    a = 32'h21; b = 32'h12; sub = 1'b0; cin = 1'b0; start[0] = 1'b1;
    pulses = 0; first_e = -1; last_e = -1;
    for (int ed = 0; ed < 9; ed++) begin
      @(posedge clk); #1;
      if (vld[0]) begin
        pulses++;
        if (first_e < 0) first_e = ed;
        last_e = ed;
        chk("held sum", sumv[0], 32'h33);
      end
    end
    start[0] = 1'b0;
    chk("held pulses", pulses, 32'd3);
    chk("held first", first_e, 32'd2);
    chk("held last", last_e, 32'd8);

    // reset mid-RUN at idx=1, on what would have been the final chunk edge
    run_op(0, 32'hC3, 32'h5A, 1'b0, 1'b1, 32'h1E, 1'b1, 1'b0, 1'b0, "w8c4 c3+5a+1", 1'b0);
    @(negedge clk);
    a = 32'h11; b = 32'h22; sub = 1'b0; cin = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst ready", {31'b0, rdy[0]}, 32'd1);
    chk("rst valid", {31'b0, vld[0]}, 32'd0);
    chk("rst sum", sumv[0], 32'd0);
    chk("rst flags", {29'b0, co[0], ov[0], z[0]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (vld[0]) cnt++;
    end
    chk("rst no_valid", cnt, 32'd0);

    // reset wins over start on the same edge
    @(negedge clk);
    reset = 1'b1; start[0] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start[0] = 1'b0;
    chk("rst+start ready", {31'b0, rdy[0]}, 32'd1);
    cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (vld[0]) cnt++;
    end
    chk("rst+start no_valid", cnt, 32'd0);
    run_op(0, 32'h12, 32'h34, 1'b0, 1'b0, 32'h46, 1'b0, 1'b0, 1'b0, "w8c4 after reset", 1'b0);

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 8; i++) begin
        ra = $urandom; rb = $urandom;
        rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
        if (i == 0) begin ra = 32'h0; rb = 32'h0; rs = 1'b1; end
        if (i == 1) begin ra = 32'hFFFF_FFFF; rb = 32'h0; rs = 1'b0; rc = 1'b1; end
        e = ref_calc(WID[k], ra, rb, rs, rc);
        run_op(k, ra, rb, rs, rc, e[31:0], e[32], e[33], e[34], "sweep", 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder/subtractor for the single-cycle processor's arithmetic library. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, holding the carry between chunks, and produces carry, overflow and zero flags with a start/valid handshake. It extends the one-bit full adder cell to arbitrary width and adds subtraction. It is the area-lean alternative to a full-width ripple adder, for ALU variants and the test harness.

## Interface
- WIDTH, 32: operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8: bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only on an edge where ready=1.
- ready  out  1  high when a new start will be accepted.
- a  in  WIDTH  operand A; sampled only on an accepted start.
- b  in  WIDTH  operand B; sampled only on an accepted start.
- sub  in  1  0 selects A+B+cin; 1 selects A−B (A+~B+1, cin ignored); sampled only on an accepted start.
- cin  in  1  carry-in for add; sampled only on an accepted start.
- valid  out  1  one-cycle pulse: result outputs are valid.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB; for sub, 1 means no borrow (A ≥ B unsigned).
- overflow  out  1  signed overflow: carry into the MSB XOR carry out of the MSB.
- zero  out  1  sum == 0.

## Operation
- NCHUNK = WIDTH/CHUNK.
- States:
  - IDLE: ready=1.
  - RUN: ready=0; a chunk index counts 0..NCHUNK−1.
  - DONE: ready=1, valid=1.
- Accepted start (IDLE or DONE, start=1):
  - Latch a.
  - Latch b, or ~b when sub=1.
  - Set the carry register to cin when sub=0, or to 1 when sub=1.
  - Clear the index and enter RUN.
- Each RUN cycle:
  - Adds latched A and B slice [idx*CHUNK +: CHUNK] plus the carry register.
  - Writes the slice into the sum register, updates the carry register, increments idx.
- On the edge that processes idx=NCHUNK−1:
  - Capture the carry into the MSB for the overflow flag.
  - Enter DONE.
- DONE lasts exactly one cycle, then returns to IDLE. A start in DONE is accepted (back-to-back) and goes straight to RUN.
- start in RUN is ignored; it is not queued.
- sum, cout, overflow and zero are registered:
  - They update only as the final chunk completes.
  - They hold until the next operation completes.
  - The sum register may update chunk-by-chunk internally, but the sum output must not change until DONE.
- Reset, including mid-RUN, forces:
  - State IDLE.
  - ready=1, valid=0, sum=0, cout=0, overflow=0, zero=0.
  - Any in-flight operation is discarded, with no valid pulse.

## Timing
- Start accepted at edge T: RUN from T. Chunk i is processed at edge T+1+i.
- valid is high in the cycle after edge T+NCHUNK; latency is NCHUNK+1 cycles from start to valid.
- ready is low from T through edge T+NCHUNK. Sustained throughput is one result per NCHUNK+1 cycles.
- CHUNK=WIDTH gives NCHUNK=1: valid two cycles after start, and the state machine is unchanged.
- Reset has priority over start on the same edge.

## Structure
- Put NCHUNK, the IDLE/RUN/DONE state encodings and the index width ($clog2(NCHUNK), minimum 1) in a shared package or include, adder_defs, reused by later ALU blocks.
- Sub-module chunk_adder: combinational CHUNK-bit ripple of full-adder cells.
  - Inputs: x, y, ci.
  - Outputs: s, co, and c_msb (the carry into its top bit, used for overflow).
- Top level: FSM, operand/carry/index registers, flag registers.

## Test plan
- WIDTH=8, CHUNK=4: a=0x0F, b=0x01, sub=0, cin=0 → valid 3 cycles after start, sum=0x10, cout=0, overflow=0, zero=0.
- WIDTH=8, CHUNK=4: a=0x7F, b=0x01, add → sum=0x80, overflow=1, cout=0. Then a=0xFF, b=0x01 → sum=0x00, cout=1, zero=1, overflow=0.
- WIDTH=32, CHUNK=8: a=5, b=7, sub=1, cin=1 → sum=0xFFFFFFFE, cout=0, overflow=0; cin is ignored. Then a=7, b=5, sub=1 → sum=2, cout=1.
- Back-to-back and busy handling: start held high continuously → valid pulses every NCHUNK+1 cycles. Extra starts during RUN → no extra results, operands unchanged.
- reset asserted at RUN idx=1 → next cycle ready=1, all outputs 0, no valid. A fresh start completes correctly.
- Sweep WIDTH/CHUNK ∈ {8/1, 8/8, 16/4, 32/8}: exhaustive or random a, b, sub, cin versus a reference model of a+b+cin or a−b, checking sum, cout, overflow and zero.
